vga_frame_monitor: RTL and testbench

Receive-side checker for the VGA output of the alarm design. It consumes hsync/vsync/rgb_565 exactly as the display would see them and recovers the pixel grid. It measures line and frame timing, locks to a standard frame, and checksums the active pixels. It can also capture one probe pixel per frame, so that benches and an on-board self-test can verify the transmitter.

---
 rtl/vga_mon_pkg.sv | 49 ++++
 rtl/vga_frame_monitor_if.sv | 17 +
 rtl/vga_sync_edge.sv | 32 +++
 rtl/vga_frame_monitor.sv | 252 +++++++++++++++++++++++++
 tb/tb_vga_frame_monitor.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_mon_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_mon_pkg
//  Description : Shared timing constants, monitor FSM states and helper
//                functions for the VGA frame monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_mon_pkg;

    // Standard 640x480 @ 60 Hz timing, in pixels and lines
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BACK   = 48;
    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FRONT  = 16;
    localparam int unsigned VGA_H_TOTAL  = VGA_H_SYNC + VGA_H_BACK + VGA_H_ACTIVE + VGA_H_FRONT;

    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BACK   = 33;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FRONT  = 10;
    localparam int unsigned VGA_V_TOTAL  = VGA_V_SYNC + VGA_V_BACK + VGA_V_ACTIVE + VGA_V_FRONT;

    // Lock state of the monitor
    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } mon_state_t;

    // Increment that sticks at the top of a 12-bit range
    function automatic logic [11:0] sat_inc12(input logic [11:0] v);
        return (v == 12'hFFF) ? v : v + 12'd1;
    endfunction

    // CRC-16-CCITT over one 16-bit word, MSB first, poly 0x1021, no reflection
    function automatic logic [15:0] crc16_ccitt_step(input logic [15:0] crc,
                                                     input logic [15:0] data);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = 15; i >= 0; i--) begin
            fb = c[15] ^ data[i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_frame_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_frame_monitor_if
//  Description : VGA pixel stream as seen by a display: pixel strobe,
//                active-low syncs and RGB565 data.
//  Revision    : 1.0 - initial release
// ============================================================================
interface vga_frame_monitor_if;
    logic        pix_ce;
    logic        hsync;
    logic        vsync;
    logic [15:0] rgb_565;

    modport master (output pix_ce, output hsync, output vsync, output rgb_565);
    modport slave  (input  pix_ce, input  hsync, input  vsync, input  rgb_565);
endinterface
`default_nettype wire

// File: rtl/vga_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : vga_sync_edge
//  Description : Strobe-qualified level register for one sync line with
//                fall/rise detection against the current input.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_edge (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic pix_ce,
    input  wire logic sync_in,
    output logic      fall,
    output logic      rise
);

    logic r_level;

    // Remember the sync level seen on the previous strobe; idle level is high
    always_ff @(posedge clk) begin
        if (rst) begin
            r_level <= 1'b1;
        end else if (pix_ce) begin
            r_level <= sync_in;
        end
    end

    assign fall = pix_ce &  r_level & ~sync_in;
    assign rise = pix_ce & ~r_level &  sync_in;

endmodule
`default_nettype wire

// File: rtl/vga_frame_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : vga_frame_monitor
//  Description : Receive-side VGA checker. Recovers the pixel grid from
//                hsync/vsync, measures line/frame timing, locks to the
//                expected frame, checksums active pixels and captures one
//                probe pixel per clean frame.
//                Build option VGA_MON_CRC_EN: checksum becomes CRC-16-CCITT
//                (init 0xFFFF) instead of the mod-2^16 additive sum.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_frame_monitor
    import vga_mon_pkg::*;
#(
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BACK   = VGA_H_BACK,
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FRONT  = VGA_H_FRONT,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BACK   = VGA_V_BACK,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FRONT  = VGA_V_FRONT
) (
    input  wire logic          clk,
    input  wire logic          rst,
    vga_frame_monitor_if.slave vga,
    input  wire logic [9:0]    probe_x,
    input  wire logic [9:0]    probe_y,
    output logic               locked,
    output logic               timing_err,
    output logic [11:0]        h_total_meas,
    output logic [11:0]        v_total_meas,
    output logic               frame_done,
    output logic [15:0]        frame_sum,
    output logic [15:0]        probe_rgb,
    output logic [7:0]         frame_cnt
);

    localparam logic [11:0] c_h_sync    = 12'(H_SYNC);
    localparam logic [11:0] c_h_total   = 12'(H_SYNC + H_BACK + H_ACTIVE + H_FRONT);
    localparam logic [11:0] c_h_act_lo  = 12'(H_SYNC + H_BACK);
    localparam logic [11:0] c_h_act_hi  = 12'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [11:0] c_v_sync    = 12'(V_SYNC);
    localparam logic [11:0] c_v_total   = 12'(V_SYNC + V_BACK + V_ACTIVE + V_FRONT);
    localparam logic [11:0] c_v_act_lo  = 12'(V_SYNC + V_BACK);
    localparam logic [11:0] c_v_act_hi  = 12'(V_SYNC + V_BACK + V_ACTIVE);
`ifdef VGA_MON_CRC_EN
    localparam logic [15:0] c_acc_init  = 16'hFFFF;
`else
    localparam logic [15:0] c_acc_init  = 16'h0000;
`endif

    // Sync edge detection
    logic w_h_fall, w_h_rise, w_v_fall, w_v_rise;

    vga_sync_edge u_hsync_edge (
        .clk     (clk),
        .rst     (rst),
        .pix_ce  (vga.pix_ce),
        .sync_in (vga.hsync),
        .fall    (w_h_fall),
        .rise    (w_h_rise)
    );

    vga_sync_edge u_vsync_edge (
        .clk     (clk),
        .rst     (rst),
        .pix_ce  (vga.pix_ce),
        .sync_in (vga.vsync),
        .fall    (w_v_fall),
        .rise    (w_v_rise)
    );

    // Grid counters and measurement state
    logic [11:0] r_x_cnt;      // index the current strobe has unless hsync falls on it
    logic [11:0] r_y;
    logic [11:0] r_hf_cnt;     // hsync falls since the last vsync fall
    logic [11:0] r_vs_lines;   // hsync falls seen while vsync is low
    logic [11:0] r_h_meas;
    logic [11:0] r_v_meas;
    logic [15:0] r_acc;
    logic [15:0] r_probe;

    mon_state_t  r_state, w_state_nxt;
    logic        r_frame_bad, w_frame_bad_nxt;
    logic        r_timing_err;
    logic        w_frame_ok, w_set_err;

    logic        r_frame_done;
    logic [15:0] r_frame_sum;
    logic [15:0] r_probe_rgb;
    logic [7:0]  r_frame_cnt;

    logic [11:0] w_x, w_y, w_ax, w_ay, w_line_cnt;
    logic        w_h_act, w_v_act, w_active, w_probe_hit;
    logic        w_mis_raw, w_mis;
    logic [15:0] w_acc_nxt;

    // Position of the current strobe on the grid
    always_comb begin
        w_x        = w_h_fall ? 12'd0 : r_x_cnt;
        w_y        = w_v_fall ? 12'd0 : (w_h_fall ? sat_inc12(r_y) : r_y);
        w_line_cnt = w_h_fall ? sat_inc12(r_hf_cnt) : r_hf_cnt;
        w_h_act    = (w_x >= c_h_act_lo) && (w_x < c_h_act_hi);
        w_v_act    = (w_y >= c_v_act_lo) && (w_y < c_v_act_hi);
        w_active   = vga.pix_ce && w_h_act && w_v_act;
        w_ax       = w_x - c_h_act_lo;
        w_ay       = w_y - c_v_act_lo;
        w_probe_hit = w_active && (w_ax == {2'b00, probe_x}) && (w_ay == {2'b00, probe_y});
`ifdef VGA_MON_CRC_EN
        w_acc_nxt  = crc16_ccitt_step(r_acc, vga.rgb_565);
`else
        w_acc_nxt  = r_acc + vga.rgb_565;
`endif
    end

    // Timing checks; the line length uses the count before the fall restarts it
    always_comb begin
        w_mis_raw = (w_h_fall && (r_x_cnt    != c_h_total)) ||
                    (w_h_rise && (w_x        != c_h_sync))  ||
                    (w_v_fall && (w_line_cnt != c_v_total)) ||
                    (w_v_rise && (r_vs_lines != c_v_sync));
        w_mis     = w_mis_raw && (r_state != SEARCH);
    end

    // Grid counters, measurements, checksum and probe capture, all per strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x_cnt    <= 12'd0;
            r_y        <= 12'd0;
            r_hf_cnt   <= 12'd0;
            r_vs_lines <= 12'd0;
            r_h_meas   <= 12'd0;
            r_v_meas   <= 12'd0;
            r_acc      <= 16'h0000;
            r_probe    <= 16'h0000;
        end else if (vga.pix_ce) begin
            r_x_cnt <= sat_inc12(w_x);
            r_y     <= w_y;

            if (w_v_fall) begin
                r_hf_cnt <= 12'd0;
            end else if (w_h_fall) begin
                r_hf_cnt <= sat_inc12(r_hf_cnt);
            end

            if (w_v_fall) begin
                r_vs_lines <= w_h_fall ? 12'd1 : 12'd0;
            end else if (w_h_fall && !vga.vsync) begin
                r_vs_lines <= sat_inc12(r_vs_lines);
            end

            if (w_h_fall) begin
                r_h_meas <= r_x_cnt;
            end
            if (w_v_fall) begin
                r_v_meas <= w_line_cnt;
            end

            if (w_v_fall) begin
                r_acc <= c_acc_init;
            end else if (w_active) begin
                r_acc <= w_acc_nxt;
            end

            if (w_v_fall) begin
                r_probe <= 16'h0000;
            end else if (w_probe_hit) begin
                r_probe <= vga.rgb_565;
            end
        end
    end

    // Lock FSM state register plus sticky timing error
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= SEARCH;
            r_frame_bad  <= 1'b0;
            r_timing_err <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_frame_bad  <= w_frame_bad_nxt;
            r_timing_err <= r_timing_err | w_set_err;
        end
    end

    // Lock FSM next state; a frame is clean only if its closing vsync fall is clean too
    always_comb begin
        w_state_nxt     = r_state;
        w_frame_bad_nxt = r_frame_bad;
        w_frame_ok      = 1'b0;
        w_set_err       = 1'b0;
        case (r_state)
            SEARCH: begin
                if (w_v_fall) begin
                    w_state_nxt     = MEASURE;
                    w_frame_bad_nxt = 1'b0;
                end
            end
            MEASURE: begin
                if (w_v_fall) begin
                    w_frame_bad_nxt = 1'b0;
                    if (!r_frame_bad && !w_mis) begin
                        w_state_nxt = LOCKED;
                        w_frame_ok  = 1'b1;
                    end
                end else if (w_mis) begin
                    w_frame_bad_nxt = 1'b1;
                end
            end
            LOCKED: begin
                if (w_mis) begin
                    w_state_nxt = SEARCH;
                    w_set_err   = 1'b1;
                end else if (w_v_fall) begin
                    w_frame_ok  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = SEARCH;
            end
        endcase
    end

    // Publish results of a clean frame one clock after its closing vsync fall
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_done <= 1'b0;
            r_frame_sum  <= 16'h0000;
            r_probe_rgb  <= 16'h0000;
            r_frame_cnt  <= 8'd0;
        end else begin
            r_frame_done <= w_frame_ok;
            if (w_frame_ok) begin
                r_frame_sum <= r_acc;
                r_probe_rgb <= r_probe;
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    assign locked       = (r_state == LOCKED);
    assign timing_err   = r_timing_err;
    assign h_total_meas = r_h_meas;
    assign v_total_meas = r_v_meas;
    assign frame_done   = r_frame_done;
    assign frame_sum    = r_frame_sum;
    assign probe_rgb    = r_probe_rgb;
    assign frame_cnt    = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_vga_frame_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_frame_monitor
//  Description : Directed bench for vga_frame_monitor on a reduced frame
//                (line 4+3+8+2 = 17 strobes, frame 2+2+4+1 = 9 lines).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_frame_monitor;

    localparam int c_hs = 4, c_hb = 3, c_ha = 8, c_hf = 2;
    localparam int c_vs = 2, c_vb = 2, c_va = 4, c_vf = 1;
    localparam int c_ht = c_hs + c_hb + c_ha + c_hf;
    localparam int c_vt = c_vs + c_vb + c_va + c_vf;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  probe_x, probe_y;
    logic        locked, timing_err, frame_done;
    logic [11:0] h_total_meas, v_total_meas;
    logic [15:0] frame_sum, probe_rgb;
    logic [7:0]  frame_cnt;

    int          n_vec  = 0;
    int          n_miss = 0;
    int          n_done = 0;
    logic        last_done_locked = 1'b0;
    logic [15:0] g_acc, g_frame_sum;

    vga_frame_monitor_if u_if ();

    vga_frame_monitor #(
        .H_SYNC(c_hs), .H_BACK(c_hb), .H_ACTIVE(c_ha), .H_FRONT(c_hf),
        .V_SYNC(c_vs), .V_BACK(c_vb), .V_ACTIVE(c_va), .V_FRONT(c_vf)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .vga          (u_if),
        .probe_x      (probe_x),
        .probe_y      (probe_y),
        .locked       (locked),
        .timing_err   (timing_err),
        .h_total_meas (h_total_meas),
        .v_total_meas (v_total_meas),
        .frame_done   (frame_done),
        .frame_sum    (frame_sum),
        .probe_rgb    (probe_rgb),
        .frame_cnt    (frame_cnt)
    );

    always #5 clk = ~clk;

    // Count frame_done high cycles and note the lock state at each pulse
    always @(negedge clk) begin
        if (frame_done === 1'b1) begin
            n_done++;
            last_done_locked = locked;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Independent CRC-16-CCITT reference: fold the word in, then 16 shifts
    function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic [15:0] d);
        logic [15:0] r;
        r = c ^ d;
        for (int i = 0; i < 16; i++) begin
            r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        end
        return r;
    endfunction

    function automatic logic [15:0] model_step(input logic [15:0] a, input logic [15:0] d);
`ifdef VGA_MON_CRC_EN
        return ref_crc(a, d);
`else
        return a + d;
`endif
    endfunction

    function automatic logic [15:0] exp_sum(input logic [15:0] hand);
`ifdef VGA_MON_CRC_EN
        return g_frame_sum;
`else
        return hand;
`endif
    endfunction

    // One pixel strobe; the non-strobe clock carries inverted syncs and noise
    task automatic strobe(input logic hs, input logic vs, input logic [15:0] px);
        @(negedge clk);
        u_if.pix_ce = 1'b1; u_if.hsync = hs; u_if.vsync = vs; u_if.rgb_565 = px;
        @(negedge clk);
        u_if.pix_ce = 1'b0; u_if.hsync = ~hs; u_if.vsync = ~vs; u_if.rgb_565 = 16'($urandom);
    endtask

    // First strobe of a frame: hsync and vsync fall together
    task automatic head();
        strobe(1'b0, 1'b0, 16'hDEAD);
    endtask

    // Rest of a frame after head(). mode: 0 zero, 1 ax, 2 const 1, 3 {ay,ax}
    task automatic send_frame(input int mode, input int long_line, input int narrow_line, input int n_lines);
        int          len, hw, ax, ay;
        logic        hs, vs, act;
        logic [15:0] px;
`ifdef VGA_MON_CRC_EN
        g_acc = 16'hFFFF;
`else
        g_acc = 16'h0000;
`endif
        for (int y = 0; y < n_lines; y++) begin
            len = c_ht + ((y == long_line) ? 1 : 0);
            hw  = (y == narrow_line) ? c_hs - 1 : c_hs;
            for (int x = 0; x < len; x++) begin
                if (!(y == 0 && x == 0)) begin
                    hs  = (x < hw) ? 1'b0 : 1'b1;
                    vs  = (y < c_vs) ? 1'b0 : 1'b1;
                    act = (x >= c_hs + c_hb) && (x < c_hs + c_hb + c_ha) &&
                          (y >= c_vs + c_vb) && (y < c_vs + c_vb + c_va);
                    ax  = x - (c_hs + c_hb);
                    ay  = y - (c_vs + c_vb);
                    case (mode)
                        0:       px = 16'h0000;
                        1:       px = {6'd0, 10'(ax)};
                        2:       px = 16'h0001;
                        default: px = {8'(ay), 8'(ax)};
                    endcase
                    if (!act) px = 16'hDEAD;
                    else      g_acc = model_step(g_acc, px);
                    strobe(hs, vs, px);
                end
            end
        end
        g_frame_sum = g_acc;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        u_if.pix_ce = 1'b0; u_if.hsync = 1'b1; u_if.vsync = 1'b1; u_if.rgb_565 = 16'h0000;
        probe_x = 10'd7; probe_y = 10'd3;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check_val("rst_locked", locked, 0);
        check_val("rst_terr", timing_err, 0);
        check_val("rst_hmeas", h_total_meas, 0);
        check_val("rst_vmeas", v_total_meas, 0);
        check_val("rst_done", frame_done, 0);
        check_val("rst_sum", frame_sum, 0);
        check_val("rst_probe", probe_rgb, 0);
        check_val("rst_cnt", frame_cnt, 0);

        // Idle strobes: toggling syncs between strobes must not register as edges
        repeat (4) strobe(1'b1, 1'b1, 16'h1234);
        check_val("idle_hmeas", h_total_meas, 0);

        // F1: constant 1 -> lock and first frame_done at the 2nd vsync fall
        head();
        send_frame(2, -1, -1, c_vt); head(); @(negedge clk);
        check_val("f1_locked", locked, 1);
        check_val("f1_ndone", n_done, 1);
        check_val("f1_done_with_lock", last_done_locked, 1);
        check_val("f1_hmeas", h_total_meas, 17);
        check_val("f1_vmeas", v_total_meas, 9);
        check_val("f1_sum", frame_sum, exp_sum(16'h0020));
        check_val("f1_probe", probe_rgb, 16'h0001);
        check_val("f1_cnt", frame_cnt, 1);

        // F2: pixel = ax, probe at the last active pixel
        send_frame(1, -1, -1, c_vt); head(); @(negedge clk);
        check_val("f2_sum", frame_sum, exp_sum(16'h0070));
        check_val("f2_probe", probe_rgb, 16'h0007);
        check_val("f2_cnt", frame_cnt, 2);

        // F3: probe outside the active area
        probe_x = 10'd9; probe_y = 10'd1;
        send_frame(1, -1, -1, c_vt); head(); @(negedge clk);
        check_val("f3_probe_out", probe_rgb, 16'h0000);
        check_val("f3_cnt", frame_cnt, 3);

        // F4: one line 18 strobes long while locked
        probe_x = 10'd7; probe_y = 10'd3;
        send_frame(1, 5, -1, c_vt);
        check_val("f4_terr", timing_err, 1);
        check_val("f4_locked", locked, 0);
        head(); @(negedge clk);
        check_val("f4_locked_meas", locked, 0);
        check_val("f4_ndone", n_done, 3);
        check_val("f4_cnt", frame_cnt, 3);
        check_val("f4_sum_kept", frame_sum, exp_sum(16'h0070));

        // F5: clean frame relocks at the 2nd vsync fall after the error
        send_frame(1, -1, -1, c_vt); head(); @(negedge clk);
        check_val("f5_locked", locked, 1);
        check_val("f5_terr_sticky", timing_err, 1);
        check_val("f5_cnt", frame_cnt, 4);
        check_val("f5_probe", probe_rgb, 16'h0007);

        // Reset in the middle of a locked frame
        send_frame(1, -1, -1, 5);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check_val("mrst_locked", locked, 0);
        check_val("mrst_terr", timing_err, 0);
        check_val("mrst_hmeas", h_total_meas, 0);
        check_val("mrst_vmeas", v_total_meas, 0);
        check_val("mrst_sum", frame_sum, 0);
        check_val("mrst_probe", probe_rgb, 0);
        check_val("mrst_cnt", frame_cnt, 0);
        check_val("mrst_ndone", n_done, 4);

        // F7: first frame_done comes at the 2nd vsync fall after reset
        head();
        check_val("f7_nolock_1st", locked, 0);
        send_frame(1, -1, -1, c_vt); head(); @(negedge clk);
        check_val("f7_ndone", n_done, 5);
        check_val("f7_locked", locked, 1);
        check_val("f7_cnt", frame_cnt, 1);
        check_val("f7_vmeas", v_total_meas, 9);

        // F8: long line drops lock, next vsync fall enters MEASURE
        send_frame(1, 6, -1, c_vt); head(); @(negedge clk);
        check_val("f8_terr", timing_err, 1);
        check_val("f8_locked", locked, 0);

        // F9: narrow hsync (3 strobes) in MEASURE -> no lock, no frame_done
        send_frame(1, -1, 3, c_vt); head(); @(negedge clk);
        check_val("f9_locked", locked, 0);
        check_val("f9_ndone", n_done, 5);
        check_val("f9_cnt", frame_cnt, 1);

        // F10: {ay,ax} pixels, probe on the first active row
        probe_x = 10'd2; probe_y = 10'd0;
        send_frame(3, -1, -1, c_vt); head(); @(negedge clk);
        check_val("f10_locked", locked, 1);
        check_val("f10_sum", frame_sum, exp_sum(16'h3070));
        check_val("f10_probe", probe_rgb, 16'h0002);
        check_val("f10_cnt", frame_cnt, 2);

        // F11: all-zero pixels
        send_frame(0, -1, -1, c_vt); head(); @(negedge clk);
        check_val("f11_sum_zero", frame_sum, exp_sum(16'h0000));
        check_val("f11_ndone", n_done, 7);
        check_val("f11_cnt", frame_cnt, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
